// File: rtl/scu_dsp_dma_ctrl_if.sv
// D0 bus and DSP RAM port bundle for the SCU DSP DMA sequencer.
// master = DMA controller side, slave = D0 bus / RAM side.
interface scu_dsp_dma_ctrl_if #(
  parameter int AW = 27
);
  logic          d0_req;
  logic          d0_we;
  logic [AW-1:0] d0_a;
  logic [31:0]   d0_do;
  logic [31:0]   d0_di;
  logic          d0_ack;
  logic [7:0]    ram_a;
  logic [3:0]    ram_we;
  logic          prg_we;
  logic [3:0]    ram_re;
  logic [31:0]   ram_d;
  logic [31:0]   ram_q;

  modport master (
    output d0_req, d0_we, d0_a, d0_do,
    output ram_a, ram_we, prg_we, ram_re, ram_d,
    input  d0_di, d0_ack, ram_q
  );

  modport slave (
    input  d0_req, d0_we, d0_a, d0_do,
    input  ram_a, ram_we, prg_we, ram_re, ram_d,
    output d0_di, d0_ack, ram_q
  );
endinterface

// File: rtl/scu_dsp_dma_ctrl.sv
// SCU DSP DMA sequencer: moves words between D0 and data RAM banks 0-3 / program RAM.
// Optional feature macro SCU_DSP_DMA_HOLD_EN: HOLD=1 suppresses the D0 address write-back.
module scu_dsp_dma_ctrl #(
  parameter int AW    = 27,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             start,
  input  logic             dir,
  input  logic [2:0]       ram_sel,
  input  logic [2:0]       add_mode,
  input  logic [CNT_W-1:0] cnt,
  input  logic             hold,
  input  logic [AW-1:0]    addr_in,
  input  logic [5:0]       ct_in,
  scu_dsp_dma_ctrl_if.master bus,
  output logic             busy,
  output logic             addr_wb,
  output logic [AW-1:0]    addr_out,
  output logic             ct_wb,
  output logic [5:0]       ct_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_D0,
    ST_WR_RAM,
    ST_RD_RAM,
    ST_WR_D0,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic             dir_reg, dir_next;
  logic [2:0]       sel_reg, sel_next;
  logic [2:0]       mode_reg, mode_next;
  logic             hold_reg, hold_next;
  logic [AW-1:0]    d0_addr_reg, d0_addr_next;
  logic [7:0]       ram_addr_reg, ram_addr_next;
  logic [CNT_W:0]   cnt_reg, cnt_next;
  logic [31:0]      data_reg, data_next;
  logic             q_cap_reg, q_cap_next;

  logic [AW-1:0]    step;
  logic [7:0]       ram_inc;
  logic             data_ram;
  logic             prg_ram;
  wire  [3:0]       bank_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      assign bank_hit[gi] = (sel_reg == 3'(gi));
    end
  endgenerate

  assign data_ram = (sel_reg < 3'd4);
  assign prg_ram  = (sel_reg == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      dir_reg      <= 1'b0;
      sel_reg      <= 3'd0;
      mode_reg     <= 3'd0;
      hold_reg     <= 1'b0;
      d0_addr_reg  <= '0;
      ram_addr_reg <= 8'd0;
      cnt_reg      <= '0;
      data_reg     <= 32'd0;
      q_cap_reg    <= 1'b0;
    end else if (ce) begin
      state_reg    <= state_next;
      dir_reg      <= dir_next;
      sel_reg      <= sel_next;
      mode_reg     <= mode_next;
      hold_reg     <= hold_next;
      d0_addr_reg  <= d0_addr_next;
      ram_addr_reg <= ram_addr_next;
      cnt_reg      <= cnt_next;
      data_reg     <= data_next;
      q_cap_reg    <= q_cap_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    dir_next      = dir_reg;
    sel_next      = sel_reg;
    mode_next     = mode_reg;
    hold_next     = hold_reg;
    d0_addr_next  = d0_addr_reg;
    ram_addr_next = ram_addr_reg;
    cnt_next      = cnt_reg;
    data_next     = data_reg;
    q_cap_next    = q_cap_reg;

    step = '0;
    if (mode_reg != 3'd0) begin
      step = AW'(1) << ({1'b0, mode_reg} + 4'd1);
    end
    // Program RAM walks the full 8-bit space; data RAM wraps inside its 64-word bank.
    ram_inc = prg_ram ? (ram_addr_reg + 8'd1) : {2'b00, ram_addr_reg[5:0] + 6'd1};

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          dir_next      = dir;
          sel_next      = ram_sel;
          mode_next     = add_mode;
          hold_next     = hold;
          d0_addr_next  = addr_in;
          ram_addr_next = (ram_sel == 3'd4) ? 8'd0 : {2'b00, ct_in};
          cnt_next      = (cnt == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, cnt};
          state_next    = dir ? ST_RD_RAM : ST_RD_D0;
        end
      end
      ST_RD_D0: begin
        if (bus.d0_ack) begin
          data_next    = bus.d0_di;
          d0_addr_next = d0_addr_reg + step;
          state_next   = ST_WR_RAM;
        end
      end
      ST_WR_RAM: begin
        ram_addr_next = ram_inc;
        cnt_next      = cnt_reg - 1'b1;
        state_next    = (cnt_reg == 1) ? ST_DONE : ST_RD_D0;
      end
      ST_RD_RAM: begin
        ram_addr_next = ram_inc;
        q_cap_next    = 1'b0;
        state_next    = ST_WR_D0;
      end
      ST_WR_D0: begin
        // RAM_Q is only guaranteed the cycle after the read strobe; hold it for ACK waits.
        if (!q_cap_reg) begin
          data_next  = bus.ram_q;
          q_cap_next = 1'b1;
        end
        if (bus.d0_ack) begin
          d0_addr_next = d0_addr_reg + step;
          cnt_next     = cnt_reg - 1'b1;
          state_next   = (cnt_reg == 1) ? ST_DONE : ST_RD_RAM;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    bus.d0_req = (state_reg == ST_RD_D0) || (state_reg == ST_WR_D0);
    bus.d0_we  = (state_reg == ST_WR_D0);
    bus.d0_a   = d0_addr_reg;
    bus.d0_do  = 32'd0;
    if ((state_reg == ST_WR_D0) && data_ram) begin
      bus.d0_do = q_cap_reg ? data_reg : bus.ram_q;
    end
    bus.ram_a  = ram_addr_reg;
    bus.ram_we = ((state_reg == ST_WR_RAM) && data_ram) ? bank_hit : 4'b0000;
    bus.prg_we = (state_reg == ST_WR_RAM) && prg_ram;
    bus.ram_re = ((state_reg == ST_RD_RAM) && data_ram) ? bank_hit : 4'b0000;
    bus.ram_d  = ((state_reg == ST_WR_RAM) && (data_ram || prg_ram)) ? data_reg : 32'd0;

    busy     = (state_reg != ST_IDLE);
    ct_wb    = (state_reg == ST_DONE) && data_ram;
    addr_out = d0_addr_reg;
    ct_out   = ram_addr_reg[5:0];
  end

`ifdef SCU_DSP_DMA_HOLD_EN
  assign addr_wb = (state_reg == ST_DONE) && !hold_reg;
`else
  logic unused_hold;
  assign unused_hold = hold_reg;
  assign addr_wb     = (state_reg == ST_DONE);
`endif

endmodule
